// File: rtl/xy_frame_player.sv
// Double-buffered X/Y point-frame player: a producer fills one bank while the
// other bank loops out to the DACs; banks swap only on a frame boundary.
module xy_frame_player #(
  parameter int DAC_BITS = 8,
  parameter int DEPTH    = 256,
  parameter int DIVIDER  = 12
) (
  input  logic                CLOCK_50,
  input  logic                KEY0,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DAC_BITS-1:0] wr_x,
  input  logic [DAC_BITS-1:0] wr_y,
  input  logic                wr_last,
  output logic [DAC_BITS-1:0] x_dac,
  output logic [DAC_BITS-1:0] y_dac,
  output logic                sample_strobe,
  output logic                frame_start,
  output logic                blank
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DIVIDER);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIVIDER - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);

  typedef enum logic {FILL, PENDING} wr_state_t;
  typedef enum logic {IDLE, PLAY} play_state_t;

  wr_state_t   wr_state, wr_state_next;
  play_state_t play_state, play_state_next;

  // Both banks live in one array addressed by {bank, index}.
  logic [2*DAC_BITS-1:0] mem [2*DEPTH];

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic [AW:0]   pend_len;
  logic [AW:0]   play_len;
  logic [AW-1:0] rd_idx, rd_idx_next;
  logic [AW:0]   rd_addr;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          wr_fire;
  logic          commit;
  logic          swap;
  logic          frame_tick;

  assign tick    = (div_cnt == DIV_LAST);
  assign wr_fire = wr_valid && wr_ready;
  assign commit  = wr_fire && (wr_last || (wr_cnt == LAST_ADDR));
  assign blank   = (play_state == IDLE);

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      FILL:    if (commit) wr_state_next = PENDING;
      PENDING: if (swap)   wr_state_next = FILL;
      default: wr_state_next = FILL;
    endcase
  end

  // Swap decision looks only at the registered writer state, so a frame
  // committed on a boundary edge waits for the following boundary.
  always_comb begin
    play_state_next = play_state;
    rd_idx_next     = rd_idx;
    swap            = 1'b0;
    frame_tick      = 1'b0;
    case (play_state)
      IDLE: begin
        if (tick && (wr_state == PENDING)) begin
          swap            = 1'b1;
          frame_tick      = 1'b1;
          rd_idx_next     = '0;
          play_state_next = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (({1'b0, rd_idx} + LEN_ONE) == play_len) begin
            frame_tick  = 1'b1;
            rd_idx_next = '0;
            swap        = (wr_state == PENDING);
          end else begin
            rd_idx_next = rd_idx + IDX_ONE;
          end
        end
      end
      default: play_state_next = IDLE;
    endcase
  end

  // On a swap the new play bank is the current write bank.
  assign rd_addr = {(swap ? wr_bank : ~wr_bank), rd_idx_next};

  always_ff @(posedge CLOCK_50) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= {wr_x, wr_y};
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      wr_state      <= FILL;
      play_state    <= IDLE;
      wr_ready      <= 1'b1;
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      pend_len      <= LEN_ONE;
      play_len      <= LEN_ONE;
      rd_idx        <= '0;
      div_cnt       <= '0;
      x_dac         <= '0;
      y_dac         <= '0;
      sample_strobe <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      wr_state      <= wr_state_next;
      play_state    <= play_state_next;
      wr_ready      <= (wr_state_next == FILL);
      div_cnt       <= tick ? '0 : div_cnt + DIV_ONE;
      sample_strobe <= tick;
      frame_start   <= frame_tick;
      rd_idx        <= rd_idx_next;
      if (wr_fire) wr_cnt <= commit ? '0 : wr_cnt + IDX_ONE;
      if (commit) pend_len <= {1'b0, wr_cnt} + LEN_ONE;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        play_len <= pend_len;
      end
      if (tick && (play_state_next == PLAY)) {x_dac, y_dac} <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_xy_frame_player.sv
// Bench for xy_frame_player: frames are modelled as point queues and every
// cycle the DUT outputs are compared against the queue-based reference.
module tb_xy_frame_player;

  localparam int DAC_BITS = 8;
  localparam int DEPTH    = 256;
  localparam int DIVIDER  = 12;

  logic                CLOCK_50 = 1'b0;
  logic                KEY0 = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [DAC_BITS-1:0] wr_x = '0;
  logic [DAC_BITS-1:0] wr_y = '0;
  logic                wr_last = 1'b0;
  logic [DAC_BITS-1:0] x_dac, y_dac;
  logic                sample_strobe, frame_start, blank;

  xy_frame_player #(.DAC_BITS(DAC_BITS), .DEPTH(DEPTH), .DIVIDER(DIVIDER)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_last(wr_last), .x_dac(x_dac), .y_dac(y_dac),
    .sample_strobe(sample_strobe), .frame_start(frame_start), .blank(blank)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {logic [7:0] x; logic [7:0] y;} pt_t;

  int tests = 0;
  int fails = 0;

  // Reference model: frames as queues of points.
  pt_t  play_q[$];
  pt_t  pend_q[$];
  pt_t  cur_q[$];
  bit   pend_valid, playing, last_fire;
  int   idx, edges;
  logic [7:0] ex, ey;
  bit   es, efs, eready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("x_dac", 32'(x_dac), 32'(ex));
    check("y_dac", 32'(y_dac), 32'(ey));
    check("sample_strobe", 32'(sample_strobe), 32'(es));
    check("frame_start", 32'(frame_start), 32'(efs));
    check("blank", 32'(blank), 32'(!playing));
    check("wr_ready", 32'(wr_ready), 32'(eready));
  endtask

  task automatic model_reset();
    play_q.delete(); pend_q.delete(); cur_q.delete();
    pend_valid = 0; playing = 0; idx = 0; edges = 0;
    ex = 0; ey = 0; es = 0; efs = 0; eready = 1; last_fire = 0;
  endtask

  // One clock edge: predict what the DUT does on it, then compare.
  task automatic step();
    bit fire;
    bit tick;
    pt_t p;
    fire = wr_valid && eready;
    @(posedge CLOCK_50);
    edges++;
    tick = (edges % DIVIDER) == 0;
    es = tick;
    efs = 0;
    if (tick) begin
      if (!playing) begin
        if (pend_valid) begin
          play_q = pend_q; pend_valid = 0; playing = 1; idx = 0; efs = 1;
          ex = play_q[0].x; ey = play_q[0].y;
        end
      end else begin
        idx++;
        if (idx >= play_q.size()) begin
          idx = 0; efs = 1;
          if (pend_valid) begin play_q = pend_q; pend_valid = 0; end
        end
        ex = play_q[idx].x; ey = play_q[idx].y;
      end
    end
    if (fire) begin
      p.x = wr_x; p.y = wr_y;
      cur_q.push_back(p);
      if (wr_last || cur_q.size() == DEPTH) begin
        pend_q = cur_q; cur_q.delete(); pend_valid = 1;
      end
    end
    eready = !pend_valid;
    last_fire = fire;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    wr_valid = 0; wr_last = 0;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input bit last);
    int n;
    n = 0;
    wr_x = x; wr_y = y; wr_last = last; wr_valid = 1;
    do begin step(); n++; end while (!last_fire && n < 8000);
    tests++;
    assert (last_fire) else begin
      fails++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, 32'(x_dac), 32'd0);
    check({tag, "_y"}, 32'(y_dac), 32'd0);
    check({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'd1);
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    int n;
    int len;
    model_reset();
    // Reset held across the first edge, released between edges.
    #8;
    check_reset_values("reset");
    #15;
    KEY0 = 1;

    // No writes for 5 ticks: blank, strobes only.
    idle(5 * DIVIDER);

    // Frame A: 4 points.
    for (int i = 0; i < 4; i++) send(8'(10 + i), 8'(20 + i), i == 3);
    check("a_ready_drop", 32'(wr_ready), 32'd0);
    idle(10 * DIVIDER + 3);
    check("a_playing_blank", 32'(blank), 32'd0);

    // Frame B: 2 points committed mid-frame.
    idle(2 * DIVIDER + 5);
    send(8'd200, 8'd5, 0);
    send(8'd201, 8'd6, 1);
    idle(10 * DIVIDER);

    // 256 random points without wr_last: the last one is forced.
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 8'($urandom), 0);
    check("full_ready_drop", 32'(wr_ready), 32'd0);
    wr_x = 8'hEE; wr_y = 8'hEE; wr_valid = 1;
    step();
    wr_valid = 0;
    idle(2 * DEPTH * DIVIDER + 3 * DIVIDER);

    // Frame C (3 points), then frame D whose last lands on a boundary tick.
    send(8'd30, 8'd40, 0);
    send(8'd31, 8'd41, 0);
    send(8'd32, 8'd42, 1);
    send(8'd90, 8'd91, 0);
    n = 0;
    while (!((edges + 1) % DIVIDER == 0 && playing && idx == play_q.size() - 1 && play_q[0].x == 8'd30)
           && n < 2000) begin
      step(); n++;
    end
    check("same_edge_reached", 32'(n < 2000), 32'd1);
    send(8'd92, 8'd93, 1);
    check("same_edge_replay_x", 32'(x_dac), 32'd30);
    check("same_edge_replay_fs", 32'(frame_start), 32'd1);
    idle(3 * DIVIDER);
    check("next_boundary_swap_x", 32'(x_dac), 32'd90);
    check("next_boundary_swap_fs", 32'(frame_start), 32'd1);
    idle(4 * DIVIDER);

    // One-point frame.
    send(8'd77, 8'd88, 1);
    idle(6 * DIVIDER);

    // Random short frames with random gaps.
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), 8'($urandom), i == len - 1);
        idle($urandom_range(0, 3));
      end
      idle($urandom_range(DIVIDER, 9 * DIVIDER));
    end

    // Reset mid-frame with a frame pending.
    for (int i = 0; i < 5; i++) send(8'($urandom), 8'($urandom), i == 4);
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), i == 2);
    idle(DIVIDER + 5);
    check("pre_reset_pending", 32'(wr_ready), 32'd0);
    #2;
    KEY0 = 0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    check_reset_values("held_reset");
    KEY0 = 1;
    idle(4 * DIVIDER);
    send(8'd55, 8'd66, 0);
    send(8'd57, 8'd68, 1);
    idle(6 * DIVIDER);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xy_frame_player.md
# xy_frame_player

Double-buffered X/Y point-frame player for the oscilloscope vector display. A producer (character renderer or command decoder) writes a frame of (x, y) points into the write bank over a valid/ready handshake. Playback replays the committed bank to the X/Y DAC pins at a fixed sample rate, looping it continuously. Banks swap only on a frame boundary, so the beam never draws a half-written frame.

## Interface
- `DAC_BITS`, 8: width of each DAC sample.
- `DEPTH`, 256: points per bank; power of two, ≥4.
- `DIVIDER`, 12: CLOCK_50 cycles per output sample; ≥2.

- `CLOCK_50`  in  1  sole clock; all state on its rising edge.
- `KEY0`  in  1  reset; asynchronous, active-low.
- `wr_valid`  in  1  producer offers a point.
- `wr_ready`  out  1  player accepts; transfer when `wr_valid && wr_ready`.
- `wr_x`, `wr_y`  in  DAC_BITS each  point coordinates.
- `wr_last`  in  1  qualifies the transfer as the final point of the frame.
- `x_dac`, `y_dac`  out  DAC_BITS each  DAC drive (`x_dac` → GPIO_0[DAC_BITS-1:0], `y_dac` → next DAC_BITS bits at top level).
- `sample_strobe`  out  1  one-cycle pulse on the edge where `x_dac`/`y_dac` update.
- `frame_start`  out  1  one-cycle pulse, coincident with `sample_strobe`, when point 0 of a frame is output.
- `blank`  out  1  high while no frame has ever been committed.

## Operation
- Storage: two banks, each DEPTH × 2·DAC_BITS. Bank pointers: `wr_bank` and `rd_bank = ~wr_bank`. Registered lengths: `play_len` and `pend_len`, 1..DEPTH.
- Writer FSM, FILL:
  - `wr_ready=1`.
  - Each transfer writes mem[wr_bank][wr_cnt] and increments `wr_cnt`.
  - A transfer with `wr_last=1`, or the transfer at `wr_cnt==DEPTH-1` (forced last), sets `pend_len=wr_cnt+1` and `wr_cnt=0`, and moves to PENDING.
- Writer FSM, PENDING:
  - `wr_ready=0`.
  - Exits to FILL on the edge that performs a swap.
  - The write bank then becomes the former play bank; its old contents are overwritten.
- Sample tick: a divider counter runs 0..DIVIDER-1 and ticks when it equals DIVIDER-1. The counter is free-running out of reset, including in IDLE.
- Player FSM, IDLE (`blank=1`):
  - Outputs hold.
  - On a tick with writer in PENDING: swap, set `rd_idx=0`, output point 0, move to PLAY.
- Player FSM, PLAY: on each tick, output mem[rd_bank][rd_idx].
  - If `rd_idx == play_len-1`, the next tick is a frame boundary.
  - Otherwise `rd_idx++`.
- Frame boundary tick: `rd_idx=0`, then one of:
  - Writer PENDING: swap (`wr_bank` toggles, `play_len=pend_len`) and output point 0 of the new frame.
  - Otherwise: replay point 0 of the same frame.
  - Either way `frame_start=1`.
- The swap decision uses writer state registered before the edge. A `wr_last` accepted on the same edge as a boundary tick does not swap on that tick; it waits for the next boundary.
- A one-point frame (`play_len=1`) outputs point 0 on every tick, with `frame_start` on every tick.

## Timing
- Reset values:
  - `x_dac=0`, `y_dac=0`, `sample_strobe=0`, `frame_start=0`, `blank=1`, `wr_ready=1`.
  - Writer FILL, `wr_cnt=0`, `wr_bank=0`; player IDLE, divider counter 0.
- Reset mid-operation: all of the above apply immediately. Partial and pending frames are discarded; bank contents need not be cleared.
- The first tick occurs DIVIDER cycles after reset release. Ticks then repeat every DIVIDER cycles.
- `wr_ready` is registered:
  - It drops on the edge after the last-point transfer, so a point offered the cycle after `wr_last` is not accepted.
  - It rises on the edge that performs the swap.
- From a committed write to its visible output: at most one full frame of the current play length plus one tick.
- `sample_strobe` and `frame_start` are never high for two consecutive cycles, because DIVIDER ≥ 2.

## Test plan
- Reset, then no writes for 5 ticks → `blank=1`, `x_dac=y_dac=0`, `sample_strobe` pulses every 12 cycles, `frame_start` never pulses.
- Write 4 points (10,20),(11,21),(12,22),(13,23) with `wr_last` on the 4th:
  - `wr_ready` drops the next cycle.
  - At the next tick: `blank=0`, `frame_start=1`, output (10,20).
  - Output then loops (11,21),(12,22),(13,23),(10,20)…, with `frame_start` on each (10,20).
  - `wr_ready` rises on the swap edge.
- While frame A (4 points) plays, commit frame B of 2 points (200,5),(201,6) mid-frame → A finishes at (13,23), the next tick outputs (200,5) with `frame_start`, then the output alternates B.
- Write 256 points with `wr_last=0` → the 256th is forced last, `wr_ready` drops, and playback loops 256 points.
- Time `wr_last` acceptance on the same edge as a frame-boundary tick → no swap that tick (old point 0 is replayed); the swap occurs at the following boundary.
- Assert `KEY0` low mid-frame with a pending frame, between clock edges → outputs clear asynchronously to the reset values. After release, `blank=1` until a new frame is committed.
